// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with a fixed WIDTH+2 cycle occupancy and direct register-file write-back.
// Define MDU_SIGNED_EN to compile in signed operand/result handling (mdu_sign honoured).
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mdu_start,
   input  logic [1:0]       mdu_op,
   input  logic             mdu_sign,
   input  logic [WIDTH-1:0] mdu_src0,
   input  logic [WIDTH-1:0] mdu_src1,
   input  logic [4:0]       mdu_rd,
   output logic             mdu_busy,
   output logic             mdu_done,
   output logic             mdu_we,
   output logic [4:0]       mdu_wa,
   output logic [WIDTH-1:0] mdu_wd
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]         state;
   logic [CW-1:0]      count;
   logic [1:0]         op;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   opnd;
   logic [4:0]         wa_q;
   logic [WIDTH-1:0]   wd_q;

   logic [WIDTH-1:0]   mag0;
   logic [WIDTH-1:0]   mag1;
   logic [2*WIDTH-1:0] prod_nxt;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] res_full;
   logic [WIDTH-1:0]   result;

`ifdef MDU_SIGNED_EN
   logic src0_neg;
   logic src1_neg;
   logic neg_a;
   logic neg_b;

   assign src0_neg = mdu_sign & mdu_src0[WIDTH-1];
   assign src1_neg = mdu_sign & mdu_src1[WIDTH-1];
   assign mag0     = src0_neg ? -mdu_src0 : mdu_src0;
   assign mag1     = src1_neg ? -mdu_src1 : mdu_src1;
`else
   logic unused_sign;

   assign unused_sign = mdu_sign;
   assign mag0        = mdu_src0;
   assign mag1        = mdu_src1;
`endif

   // prod holds {high, low} for multiply and {remainder, quotient} for divide
   always_comb begin
      mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
      div_shift = prod[2*WIDTH-1:WIDTH-1];
      div_diff  = div_shift - {1'b0, opnd};
      if (op[1]) begin
         if (div_shift >= {1'b0, opnd})
            prod_nxt = {div_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
         else
            prod_nxt = {div_shift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
      end else begin
         prod_nxt = {mul_sum, prod[WIDTH-1:1]};
      end
   end

   // A zero divisor keeps the all-ones quotient regardless of operand signs
   always_comb begin
      res_full = prod_nxt;
`ifdef MDU_SIGNED_EN
      if (op[1]) begin
         if ((neg_a ^ neg_b) && (opnd != '0))
            res_full[WIDTH-1:0] = -prod_nxt[WIDTH-1:0];
         if (neg_a)
            res_full[2*WIDTH-1:WIDTH] = -prod_nxt[2*WIDTH-1:WIDTH];
      end else if (neg_a ^ neg_b) begin
         res_full = -prod_nxt;
      end
`endif
      result = op[0] ? res_full[2*WIDTH-1:WIDTH] : res_full[WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         count <= '0;
         op    <= '0;
         prod  <= '0;
         opnd  <= '0;
         wa_q  <= '0;
         wd_q  <= '0;
`ifdef MDU_SIGNED_EN
         neg_a <= 1'b0;
         neg_b <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (mdu_start) begin
                  op    <= mdu_op;
                  wa_q  <= mdu_rd;
                  count <= '0;
                  prod  <= {{WIDTH{1'b0}}, (mdu_op[1] ? mag0 : mag1)};
                  opnd  <= mdu_op[1] ? mag1 : mag0;
`ifdef MDU_SIGNED_EN
                  neg_a <= src0_neg;
                  neg_b <= src1_neg;
`endif
                  state <= S_CALC;
               end
            end
            S_CALC: begin
               prod  <= prod_nxt;
               count <= count + 1'b1;
               if (count == CW'(WIDTH-1)) begin
                  wd_q  <= result;
                  state <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign mdu_busy = (state != S_IDLE);
   assign mdu_done = (state == S_DONE);
   assign mdu_we   = mdu_done && (wa_q != 5'd0);
   assign mdu_wa   = wa_q;
   assign mdu_wd   = wd_q;

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit multiply/divide unit between the register-file read ports and the register-file write port. Accepts two source operands and a destination register index, computes over a fixed number of cycles, then drives a single-cycle write-back (write enable, address, data) directly into the register file's write port. Serves multi-cycle MUL/MULH/DIV/MOD instructions while the CPU stalls on `mdu_busy`.

## Interface
- `WIDTH`, 32: operand/result width; the fixed latency below scales with it.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `mdu_start`  input  1  request; sampled only in IDLE.
- `mdu_op`  input  2  00 MUL (low word), 01 MULH (high word), 10 DIV (quotient), 11 MOD (remainder).
- `mdu_sign`  input  1  signed operation; ignored when `MDU_SIGNED_EN` is undefined.
- `mdu_src0`  input  WIDTH  multiplicand/dividend (register-file read port 0 data).
- `mdu_src1`  input  WIDTH  multiplier/divisor (register-file read port 1 data).
- `mdu_rd`  input  5  destination register index.
- `mdu_busy`  output  1  high whenever state ≠ IDLE.
- `mdu_done`  output  1  one-cycle completion pulse.
- `mdu_we`  output  1  register-file write enable; equals `mdu_done` && latched rd ≠ 0.
- `mdu_wa`  output  5  latched destination index.
- `mdu_wd`  output  WIDTH  result.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: on an edge with `mdu_start`=1, latch op, sign, rd, and operands (operands converted to magnitudes if signed), clear iteration counter, go to CALC. `mdu_start`=0 stays in IDLE.
- CALC: one iteration per cycle.
  - Multiply: shift-add over a 2·WIDTH product register.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - After exactly WIDTH iterations, go to DONE.
- DONE: apply result sign correction and present the result.
  - `mdu_done`=1 and `mdu_we` per rule above.
  - Next edge returns to IDLE unconditionally.
- `mdu_start` while busy, including in DONE, is ignored: no queueing, no restart.
- Operands are captured at accept. Later changes on `mdu_src*` have no effect.
- Signed result signs:
  - product and quotient: sign(a) XOR sign(b).
  - remainder: sign(a).
- Divide by zero (fixed latency, no trap): quotient = all ones (0xFFFFFFFF); remainder = dividend unchanged.
- Signed overflow, −2^31 / −1: quotient 0x80000000, remainder 0. This falls out of unsigned-magnitude arithmetic and needs no special case.
- Unsigned results are taken directly from the product/quotient/remainder registers.

## Timing
- Accept edge E0. CALC occupies the WIDTH cycles after E0; DONE is the cycle after edge E0+WIDTH.
- For WIDTH=32: `mdu_done`/`mdu_we`/`mdu_wd` are valid during the cycle following edge E32; the register file writes at edge E33.
- `mdu_busy` rises after E0 and falls after E33. The earliest next accept is E34.
- Latency is fixed for every op and operand value, including divide by zero.
- Outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- Reset values: state IDLE; `mdu_busy`, `mdu_done`, `mdu_we` = 0; `mdu_wa` = 0; `mdu_wd` = 0; counter = 0.
- Reset asserted mid-CALC or in DONE aborts the operation: no write-back occurs, and IDLE holds on the following cycle.
- Reset and `mdu_start` on the same edge: reset wins, and the request is dropped.

## Configuration
- `MDU_SIGNED_EN` defined:
  - `mdu_sign` is honoured.
  - Operand negation and result sign-correction logic are compiled in.
- `MDU_SIGNED_EN` undefined:
  - `mdu_sign` is unused; all ops are unsigned.
  - Sign logic is absent.
  - Latency and interface are unchanged.

## Test plan
- MUL unsigned 7 × 6, rd=5 → `mdu_done` at accept+33 cycles, `mdu_we`=1, `mdu_wa`=5, `mdu_wd`=42. `mdu_busy` is high for exactly 33 cycles.
- MULH unsigned 0xFFFFFFFF × 0xFFFFFFFF → `mdu_wd`=0xFFFFFFFE. With `MDU_SIGNED_EN` and sign=1, same operands → 0x00000000.
- DIV/MOD unsigned 100 / 7 → 14 and 2. DIV 5 / 0 → 0xFFFFFFFF; MOD 5 / 0 → 5.
- Signed (`MDU_SIGNED_EN`):
  - −7 / 2 → 0xFFFFFFFD; −7 mod 2 → 0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF → 0x80000000, mod → 0.
- rd=0 write suppression: result with rd=0 → `mdu_done`=1, `mdu_we`=0.
- Handshake and reset:
  - Second `mdu_start` at accept+10 with different operands → ignored; the first result is unchanged.
  - `rst` at accept+20 → no `mdu_done`, `mdu_busy`=0 next cycle.
  - A new start afterwards completes normally.
